// File: rtl/control_sequencer_pkg.sv
// Shared microstate numbering for the instruction encoder and the control sequencer.
// The State_Sel entry values are the microstate numbers themselves.
package control_sequencer_pkg;

    localparam int STATE_W = 7;

    localparam logic [STATE_W-1:0] ST_IDLE    = 7'd0;
    localparam logic [STATE_W-1:0] ST_FETCH0  = 7'd1;
    localparam logic [STATE_W-1:0] ST_FETCH1  = 7'd2;
    localparam logic [STATE_W-1:0] ST_FETCH2  = 7'd3;
    localparam logic [STATE_W-1:0] ST_DECODE  = 7'd4;
    localparam logic [STATE_W-1:0] ST_ADDU    = 7'd6;
    localparam logic [STATE_W-1:0] ST_ST_ADDR = 7'd7;
    localparam logic [STATE_W-1:0] ST_ST_DATA = 7'd8;
    localparam logic [STATE_W-1:0] ST_ST_WAIT = 7'd9;
    localparam logic [STATE_W-1:0] ST_BEQ     = 7'd11;
    localparam logic [STATE_W-1:0] ST_BR_TAKE = 7'd12;
    localparam logic [STATE_W-1:0] ST_LD_ADDR = 7'd13;
    localparam logic [STATE_W-1:0] ST_LD_WAIT = 7'd14;
    localparam logic [STATE_W-1:0] ST_LD_WB   = 7'd15;
    localparam logic [STATE_W-1:0] ST_SUBU    = 7'd17;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = ST_IDLE,
        S_FETCH0  = ST_FETCH0,
        S_FETCH1  = ST_FETCH1,
        S_FETCH2  = ST_FETCH2,
        S_DECODE  = ST_DECODE,
        S_ADDU    = ST_ADDU,
        S_ST_ADDR = ST_ST_ADDR,
        S_ST_DATA = ST_ST_DATA,
        S_ST_WAIT = ST_ST_WAIT,
        S_BEQ     = ST_BEQ,
        S_BR_TAKE = ST_BR_TAKE,
        S_LD_ADDR = ST_LD_ADDR,
        S_LD_WAIT = ST_LD_WAIT,
        S_LD_WB   = ST_LD_WB,
        S_SUBU    = ST_SUBU
    } state_e;

    function automatic logic is_entry_state(input logic [STATE_W-1:0] sel);
        return (sel == ST_ADDU) || (sel == ST_SUBU) || (sel == ST_ST_ADDR) ||
               (sel == ST_BEQ)  || (sel == ST_LD_ADDR);
    endfunction

    function automatic logic is_wait_state(input state_e s);
        return (s == S_FETCH1) || (s == S_ST_WAIT) || (s == S_LD_WAIT);
    endfunction

endpackage

// File: rtl/control_sequencer_moc_timer.sv
// Memory-wait watchdog: counts MOC-low cycles while a wait state is active and
// flags the cycle in which the wait would exceed MOC_TIMEOUT.
module moc_timer #(
    parameter int MOC_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic moc,
    output logic timeout
);

    localparam logic [3:0] TIMEOUT_LAST = 4'(MOC_TIMEOUT - 1);

    logic [3:0] count_reg;

    // Held at zero outside wait states, so every wait entry starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= 4'd0;
        end else if (!active) begin
            count_reg <= 4'd0;
        end else if (!moc) begin
            count_reg <= count_reg + 4'd1;
        end
    end

    // MOC arriving on the final cycle wins over the timeout.
    assign timeout = active && !moc && (count_reg == TIMEOUT_LAST);

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control sequencer: fetch/decode/execute FSM with a memory-wait
// watchdog. Outputs are registered from the next state, except MDR_Ld in LD_WAIT.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int MOC_TIMEOUT = 15
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [STATE_W-1:0] State_Sel,
    input  logic               MOC,
    input  logic               Cond,
    output logic [STATE_W-1:0] State,
    output logic               MFA,
    output logic               RW,
    output logic               IR_Ld,
    output logic               PC_Ld,
    output logic               MAR_Ld,
    output logic               MDR_Ld,
    output logic               RF_Ld,
    output logic               Illegal,
    output logic               Bus_Err
);

    state_e state_reg, state_next;
    logic   illegal_next, bus_err_next;
    logic   timeout;
    logic   mfa_reg, rw_reg, ir_ld_reg, pc_ld_reg, mar_ld_reg, mdr_ld_reg, rf_ld_reg;
    logic   illegal_reg, bus_err_reg;

    moc_timer #(.MOC_TIMEOUT(MOC_TIMEOUT)) u_moc_timer (
        .clk    (Clk),
        .rst    (Reset),
        .active (is_wait_state(state_reg)),
        .moc    (MOC),
        .timeout(timeout)
    );

    always_comb begin
        state_next   = S_FETCH0;
        illegal_next = 1'b0;
        bus_err_next = 1'b0;
        case (state_reg)
            S_IDLE:    state_next = S_FETCH0;
            S_FETCH0:  state_next = S_FETCH1;
            S_FETCH1: begin
                if (MOC)          state_next = S_FETCH2;
                else if (timeout) bus_err_next = 1'b1;
                else              state_next = S_FETCH1;
            end
            S_FETCH2:  state_next = S_DECODE;
            S_DECODE: begin
                if (is_entry_state(State_Sel)) state_next = state_e'(State_Sel);
                else                           illegal_next = 1'b1;
            end
            S_ST_ADDR: state_next = S_ST_DATA;
            S_ST_DATA: state_next = S_ST_WAIT;
            S_ST_WAIT: begin
                if (MOC)          state_next = S_FETCH0;
                else if (timeout) bus_err_next = 1'b1;
                else              state_next = S_ST_WAIT;
            end
            S_BEQ:     state_next = Cond ? S_BR_TAKE : S_FETCH0;
            S_LD_ADDR: state_next = S_LD_WAIT;
            S_LD_WAIT: begin
                if (MOC)          state_next = S_LD_WB;
                else if (timeout) bus_err_next = 1'b1;
                else              state_next = S_LD_WAIT;
            end
            default:   state_next = S_FETCH0;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg   <= S_IDLE;
            mfa_reg     <= 1'b0;
            rw_reg      <= 1'b0;
            ir_ld_reg   <= 1'b0;
            pc_ld_reg   <= 1'b0;
            mar_ld_reg  <= 1'b0;
            mdr_ld_reg  <= 1'b0;
            rf_ld_reg   <= 1'b0;
            illegal_reg <= 1'b0;
            bus_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mfa_reg     <= is_wait_state(state_next);
            rw_reg      <= (state_next == S_FETCH1) || (state_next == S_LD_WAIT);
            ir_ld_reg   <= (state_next == S_FETCH2);
            // PC increments only on the first FETCH1 cycle, not on each wait cycle.
            pc_ld_reg   <= ((state_next == S_FETCH1) && (state_reg != S_FETCH1)) ||
                           (state_next == S_BR_TAKE);
            mar_ld_reg  <= (state_next == S_FETCH0) || (state_next == S_ST_ADDR) ||
                           (state_next == S_LD_ADDR);
            mdr_ld_reg  <= (state_next == S_ST_DATA);
            rf_ld_reg   <= (state_next == S_ADDU) || (state_next == S_SUBU) ||
                           (state_next == S_LD_WB);
            illegal_reg <= illegal_next;
            bus_err_reg <= bus_err_next;
        end
    end

    assign State   = state_reg;
    assign MFA     = mfa_reg;
    assign RW      = rw_reg;
    assign IR_Ld   = ir_ld_reg;
    assign PC_Ld   = pc_ld_reg;
    assign MAR_Ld  = mar_ld_reg;
    assign MDR_Ld  = mdr_ld_reg | ((state_reg == S_LD_WAIT) && MOC);
    assign RF_Ld   = rf_ld_reg;
    assign Illegal = illegal_reg;
    assign Bus_Err = bus_err_reg;

endmodule
